// File: rtl/sprite_anim_ctrl.sv
// Sprite animation controller: one-deep command buffer, tear-free position and
// animation-frame updates applied only on frame_tick.
module sprite_anim_ctrl #(
    parameter int unsigned STEP     = 4,
    parameter int unsigned ANIM_DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       cmd_valid,
    input  logic [2:0] cmd,
    output logic       cmd_ready,
    output logic [9:0] pos_h,
    output logic [9:0] pos_v,
    output logic [3:0] now_pixel_idx,
    output logic [1:0] anim_state
);

    localparam int unsigned H_SIZE = 320;
    localparam int unsigned V_SIZE = 240;
    localparam int unsigned PW     = 11;

    localparam logic [2:0] CMD_LEFT   = 3'd1;
    localparam logic [2:0] CMD_RIGHT  = 3'd2;
    localparam logic [2:0] CMD_UP     = 3'd3;
    localparam logic [2:0] CMD_DOWN   = 3'd4;
    localparam logic [2:0] CMD_ATTACK = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WALK   = 2'd1,
        ST_ATTACK = 2'd2
    } state_t;

    state_t     r_state;
    logic [9:0] r_pos_h;
    logic [9:0] r_pos_v;
    logic [3:0] r_idx;
    logic [4:0] r_anim_cnt;
    logic       r_pend_vld;
    logic [2:0] r_pend_cmd;
    logic       r_init_done;

    logic          w_accept;
    logic          w_cmd_act;
    logic          w_pend_move;
    logic          w_cnt_last;
    logic [PW-1:0] w_h_sum;
    logic [PW-1:0] w_v_sum;
    logic [9:0]    w_pos_h_nxt;
    logic [9:0]    w_pos_v_nxt;

    assign cmd_ready     = r_init_done && !r_pend_vld && (r_state != ST_ATTACK);
    assign w_accept      = cmd_valid && cmd_ready;
    assign w_cmd_act     = (cmd >= CMD_LEFT) && (cmd <= CMD_ATTACK);
    assign w_pend_move   = (r_pend_cmd >= CMD_LEFT) && (r_pend_cmd <= CMD_DOWN);
    assign w_cnt_last    = (r_anim_cnt == 5'(ANIM_DIV - 1));

    assign pos_h         = r_pos_h;
    assign pos_v         = r_pos_v;
    assign now_pixel_idx = r_idx;
    assign anim_state    = r_state;

    // Modular position step; sums stay below twice the range, so one subtract wraps.
    always_comb begin
        w_h_sum     = PW'(r_pos_h);
        w_v_sum     = PW'(r_pos_v);
        w_pos_h_nxt = r_pos_h;
        w_pos_v_nxt = r_pos_v;
        case (r_pend_cmd)
            CMD_LEFT:  w_h_sum = PW'(r_pos_h) + PW'(STEP);
            CMD_RIGHT: w_h_sum = PW'(r_pos_h) + PW'(H_SIZE - STEP);
            CMD_UP:    w_v_sum = PW'(r_pos_v) + PW'(STEP);
            CMD_DOWN:  w_v_sum = PW'(r_pos_v) + PW'(V_SIZE - STEP);
            default: ;
        endcase
        if (w_h_sum >= PW'(H_SIZE)) w_h_sum = w_h_sum - PW'(H_SIZE);
        if (w_v_sum >= PW'(V_SIZE)) w_v_sum = w_v_sum - PW'(V_SIZE);
        w_pos_h_nxt = 10'(w_h_sum);
        w_pos_v_nxt = 10'(w_v_sum);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pos_h     <= '0;
            r_pos_v     <= '0;
            r_idx       <= 4'd1;
            r_anim_cnt  <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_cmd  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b1;
            if (frame_tick) begin
                r_pend_vld <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (r_pend_vld && w_pend_move) begin
                            r_state    <= ST_WALK;
                            r_idx      <= 4'd2;
                            r_anim_cnt <= '0;
                            r_pos_h    <= w_pos_h_nxt;
                            r_pos_v    <= w_pos_v_nxt;
                        end else if (r_pend_vld) begin
                            r_state    <= ST_ATTACK;
                            r_idx      <= 4'd6;
                            r_anim_cnt <= '0;
                        end
                    end
                    ST_WALK: begin
                        if (!r_pend_vld) begin
                            r_state    <= ST_IDLE;
                            r_idx      <= 4'd1;
                            r_anim_cnt <= '0;
                        end else if (!w_pend_move) begin
                            r_state    <= ST_ATTACK;
                            r_idx      <= 4'd6;
                            r_anim_cnt <= '0;
                        end else begin
                            r_pos_h <= w_pos_h_nxt;
                            r_pos_v <= w_pos_v_nxt;
                            if (w_cnt_last) begin
                                r_anim_cnt <= '0;
                                r_idx      <= (r_idx == 4'd5) ? 4'd2 : r_idx + 4'd1;
                            end else begin
                                r_anim_cnt <= r_anim_cnt + 5'd1;
                            end
                        end
                    end
                    ST_ATTACK: begin
                        if (w_cnt_last) begin
                            r_anim_cnt <= '0;
                            if (r_idx == 4'd9) begin
                                r_state <= ST_IDLE;
                                r_idx   <= 4'd1;
                            end else begin
                                r_idx <= r_idx + 4'd1;
                            end
                        end else begin
                            r_anim_cnt <= r_anim_cnt + 5'd1;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_idx      <= 4'd1;
                        r_anim_cnt <= '0;
                    end
                endcase
            end
            // A command accepted alongside a tick is held for the following tick.
            if (w_accept && w_cmd_act) begin
                r_pend_vld <= 1'b1;
                r_pend_cmd <= cmd;
            end
        end
    end

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed bench for sprite_anim_ctrl with default parameters (STEP=4, ANIM_DIV=8).
module tb_sprite_anim_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd = 3'd0;
    logic       cmd_ready;
    logic [9:0] pos_h;
    logic [9:0] pos_v;
    logic [3:0] now_pixel_idx;
    logic [1:0] anim_state;

    int n_checks = 0;
    int n_errors = 0;

    sprite_anim_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .cmd_valid    (cmd_valid),
        .cmd          (cmd),
        .cmd_ready    (cmd_ready),
        .pos_h        (pos_h),
        .pos_v        (pos_v),
        .now_pixel_idx(now_pixel_idx),
        .anim_state   (anim_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        // Reset values
        cyc();
        cyc();
        check("rst_pos_h", 32'(pos_h), 0);
        check("rst_pos_v", 32'(pos_v), 0);
        check("rst_idx", 32'(now_pixel_idx), 1);
        check("rst_state", 32'(anim_state), 0);
        check("rst_ready", 32'(cmd_ready), 0);
        rst_n = 1'b1;
        cyc();
        check("ready_after_release", 32'(cmd_ready), 1);

        // RIGHT wraps 0 -> 316; nothing moves until the tick
        send(3'd2);
        check("pending_ready", 32'(cmd_ready), 0);
        check("no_move_before_tick", 32'(pos_h), 0);
        tick();
        check("right_pos_h", 32'(pos_h), 316);
        check("right_idx", 32'(now_pixel_idx), 2);
        check("right_state", 32'(anim_state), 1);
        tick();
        check("idle_state", 32'(anim_state), 0);
        check("idle_idx", 32'(now_pixel_idx), 1);
        check("idle_pos_h", 32'(pos_h), 316);

        // NOP codes are discarded
        send(3'd0);
        check("nop0_ready", 32'(cmd_ready), 1);
        send(3'd7);
        check("nop7_ready", 32'(cmd_ready), 1);
        tick();
        check("nop_state", 32'(anim_state), 0);
        check("nop_pos_h", 32'(pos_h), 316);

        // Vertical wrap both ways
        send(3'd4);
        tick();
        check("down_pos_v", 32'(pos_v), 236);
        send(3'd3);
        tick();
        check("up_pos_v", 32'(pos_v), 0);
        tick();

        // Eight LEFT ticks from 0; frame advance on the 8th tick after WALK entry
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            send(3'd1);
            tick();
        end
        check("left8_pos_h", 32'(pos_h), 32);
        check("left8_idx", 32'(now_pixel_idx), 2);
        send(3'd1);
        tick();
        check("left9_pos_h", 32'(pos_h), 36);
        check("left9_idx", 32'(now_pixel_idx), 3);
        tick();
        check("left_idle", 32'(anim_state), 0);

        // ATTACK with cmd_valid held high throughout
        send(3'd5);
        check("atk_pending_ready", 32'(cmd_ready), 0);
        tick();
        check("atk_entry_idx", 32'(now_pixel_idx), 6);
        check("atk_entry_state", 32'(anim_state), 2);
        cmd_valid = 1'b1;
        cmd       = 3'd1;
        for (int k = 1; k <= 32; k++) begin
            cyc();
            check("atk_ready_low", 32'(cmd_ready), 0);
            tick();
            if (k < 32) begin
                check("atk_idx", 32'(now_pixel_idx), 32'(6 + k / 8));
                check("atk_ready_low_tick", 32'(cmd_ready), 0);
            end else begin
                cmd_valid = 1'b0;
                check("atk_end_idx", 32'(now_pixel_idx), 1);
                check("atk_end_state", 32'(anim_state), 0);
                check("atk_end_ready", 32'(cmd_ready), 1);
            end
        end
        check("atk_pos_h", 32'(pos_h), 36);
        cyc();

        // Command coincident with a tick acts only on the next tick
        do_reset();
        cmd_valid  = 1'b1;
        cmd        = 3'd1;
        frame_tick = 1'b1;
        cyc();
        cmd_valid  = 1'b0;
        frame_tick = 1'b0;
        check("coinc_pos_h", 32'(pos_h), 0);
        check("coinc_state", 32'(anim_state), 0);
        check("coinc_ready", 32'(cmd_ready), 0);
        tick();
        check("coinc_next_pos_h", 32'(pos_h), 4);
        check("coinc_next_state", 32'(anim_state), 1);

        // Reset aborts ATTACK at idx 8
        send(3'd5);
        tick();
        check("walk_to_atk_pos_h", 32'(pos_h), 4);
        for (int k = 1; k <= 16; k++) tick();
        check("atk_idx8", 32'(now_pixel_idx), 8);
        rst_n = 1'b0;
        cyc();
        check("abort_idx", 32'(now_pixel_idx), 1);
        check("abort_state", 32'(anim_state), 0);
        check("abort_pos_h", 32'(pos_h), 0);
        check("abort_pos_v", 32'(pos_v), 0);
        check("abort_ready", 32'(cmd_ready), 0);
        rst_n = 1'b1;
        cyc();
        check("abort_release_ready", 32'(cmd_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_anim_ctrl.md
SPRITE_ANIM_CTRL -- requirements
Module: sprite_anim_ctrl

Interface
REQ-001 Parameter STEP, default 4, pixels moved per accepted move command (1..16).
REQ-002 Parameter ANIM_DIV, default 8, frame ticks per animation-frame advance (2..15).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 frame_tick  input  1  one-cycle pulse at start of vertical blanking.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd  input  3  0=NOP, 1=LEFT, 2=RIGHT, 3=UP, 4=DOWN, 5=ATTACK, 6/7=NOP.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clock edge.
REQ-009 pos_h  output  10  horizontal scroll offset, range 0..319, feeds the pixel selector.
REQ-010 pos_v  output  10  vertical scroll offset, range 0..239, feeds the pixel selector.
REQ-011 now_pixel_idx  output  4  sprite image index, range 1..9, feeds the pixel selector.
REQ-012 anim_state  output  2  0=IDLE, 1=WALK, 2=ATTACK.

Function
REQ-013 Block SHALL hold a one-deep pending-command register (valid flag + 3-bit code).
REQ-014 cmd_ready SHALL equal (pending empty) && (anim_state != ATTACK), combinational from registers only.
REQ-015 Accepted NOP codes SHALL be discarded, pending stays empty.
REQ-016 Accepted non-NOP codes SHALL set pending; the pending value is consumed at the next frame_tick only.
REQ-017 Command accepted in the same cycle as frame_tick SHALL NOT act on that tick; it becomes pending for the following tick.
REQ-018 pos_h, pos_v, now_pixel_idx, anim_state SHALL change only in cycles where frame_tick=1 (tear-free).
REQ-019 Movement arithmetic SHALL be modular: LEFT pos_h=(pos_h+STEP)%320; RIGHT pos_h=(pos_h+320-STEP)%320; UP pos_v=(pos_v+STEP)%240; DOWN pos_v=(pos_v+240-STEP)%240; computed at 11 bits, no overflow.
REQ-020 5-bit anim_cnt SHALL count frame ticks within the current animation frame.
REQ-021 IDLE: now_pixel_idx=1; on tick with pending move -> WALK, idx=2, anim_cnt=0, position updated; pending ATTACK -> ATTACK, idx=6, anim_cnt=0; no pending -> stay.
REQ-022 WALK: tick with pending move -> position updated, anim_cnt+1; when anim_cnt reaches ANIM_DIV-1 it wraps to 0 and idx advances 2->3->4->5->2.
REQ-023 WALK: tick with pending ATTACK -> ATTACK, idx=6, anim_cnt=0, position unchanged.
REQ-024 WALK: tick with no pending -> IDLE, idx=1, anim_cnt=0.
REQ-025 ATTACK: each tick anim_cnt+1; at ANIM_DIV-1 wrap to 0 and idx advances 6->7->8->9; wrap while idx=9 -> IDLE, idx=1.
REQ-026 ATTACK lasts exactly 4*ANIM_DIV ticks; no command accepted during it.
REQ-027 Pending register SHALL clear on every frame_tick on which it is consumed.
REQ-028 now_pixel_idx SHALL never be 0 or above 9; pos_h never above 319; pos_v never above 239.

Reset
REQ-029 While rst_n=0 at a clock edge: pos_h=0, pos_v=0, now_pixel_idx=1, anim_state=IDLE, anim_cnt=0, pending empty.
REQ-030 cmd_ready SHALL be 0 while rst_n=0, and 1 from the first edge after release.
REQ-031 Reset asserted mid-ATTACK or with pending command SHALL abort it; no position change from it.

Verification
REQ-032 Reset, then RIGHT accepted, one tick -> pos_h=316, idx=2, anim_state=WALK; next tick with no command -> IDLE, idx=1, pos_h=316.
REQ-033 From pos_v=236, UP then tick -> pos_v=0; from pos_v=0, DOWN then tick -> pos_v=236.
REQ-034 LEFT issued before each of 8 consecutive ticks (ANIM_DIV=8) -> pos_h=32, idx steps 2 to 3 on the 8th tick after WALK entry.
REQ-035 ATTACK then 32 ticks with cmd_valid held high -> cmd_ready=0 throughout, idx 6,7,8,9 each for 8 ticks, then idx=1 IDLE, cmd_ready=1.
REQ-036 cmd_valid with LEFT coincident with frame_tick from IDLE -> no change on that tick; pos_h=4 after the next tick.
REQ-037 rst_n low for one cycle during ATTACK idx=8 -> next cycle idx=1, IDLE, pos unchanged reset to 0/0, cmd_ready=1 after release.
